sram_rr_arbiter: RTL and testbench
==================================

# sram_rr_arbiter

Round-robin arbiter and sequencer that shares one single-port SRAM between N_REQ requesters over a req/ack handshake. It issues one SRAM access at a time and waits a fixed read latency before returning data. It also zero-fills the whole SRAM after reset or on command. It sits between the processing units (CPU core, loader, display fetch) and the SRAM macro, replacing ad-hoc two-port muxing.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 15, SRAM address width
- DATA_W, 32, SRAM data width
- RD_LAT, 2, SRAM cycles from enable sampled to valid mem_rdata (>=1)
- CLEAR_ON_RESET, 1, zero-fill the SRAM automatically when reset is released
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- req  in  N_REQ  per-requester request level; held, with its we/addr/wdata stable, until its ack
- we  in  N_REQ  per-requester 1 = write, 0 = read
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  packed write data, same packing
- ack  out  N_REQ  one-cycle completion pulse, at most one bit high
- rdata  out  DATA_W  shared read data, valid while any ack bit is high; holds last value otherwise
- clear_req  in  1  one-cycle pulse requesting a full zero-fill
- clear_done  out  1  one-cycle pulse when a zero-fill finishes
- busy  out  1  high whenever state is not IDLE
- mem_en, mem_we  out  1  SRAM enable, write strobe
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  SRAM port

## Operation
- States: IDLE, ISSUE, WAIT, CLEAR.
- Reset (reset==0): state = CLEAR if CLEAR_ON_RESET, else IDLE. Clear counter = 0, last-grant pointer = N_REQ-1. ack = 0, rdata = 0, clear_done = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, clear-pending = 0. Any in-flight transaction is dropped without an ack.
- IDLE:
  - If clear-pending or clear_req, go to CLEAR. Clear has priority over requests.
  - Otherwise form the eligible set = req AND NOT ack. The requester being acked this cycle is excluded.
  - Winner is the first eligible index scanning from last-grant+1 upward, wrapping modulo N_REQ.
  - Latch the winner, drive mem_en=1, mem_we/mem_addr/mem_wdata from the winner, and go to ISSUE.
- ISSUE (1 cycle, mem_en high): deassert mem_en/mem_we at the next edge, load the wait counter with RD_LAT-1, and go to WAIT.
- WAIT:
  - Decrement the counter.
  - At counter 0, capture mem_rdata into rdata (reads only; rdata is unchanged on writes).
  - In the same edge, set ack[winner]=1, set last-grant = winner, and go to IDLE.
  - ack clears on the following edge.
- CLEAR:
  - Each cycle drive mem_en=1, mem_we=1, mem_wdata=0, mem_addr=counter, then increment the counter.
  - After address 2^ADDR_W-1 is written: clear_done=1 for one cycle, counter wraps to 0, clear-pending=0, go to IDLE.
- clear_req arriving outside IDLE sets clear-pending. It is serviced when the current transaction completes. Repeated pulses collapse into one clear.
- A clear_req arriving during CLEAR does not restart the clear and is not remembered.
- Requests raised during CLEAR or a transaction stay pending and are arbitrated in the next IDLE. No request is lost.
- The arbiter never reads req/we/addr/wdata except in IDLE.

## Timing
- Access: req sampled high at the end of IDLE cycle T-1. mem_en is high in cycle T only. mem_rdata is sampled at the end of cycle T+RD_LAT. ack and rdata are valid in cycle T+RD_LAT+1.
- Request-to-ack latency is RD_LAT+2 cycles from the first IDLE cycle with req high. Writes have the same latency.
- Back-to-back throughput: one access per RD_LAT+2 cycles. The ack cycle doubles as the next IDLE.
- Requester rule: drop req, or present a new transaction, on the edge after its ack.
- Zero-fill takes 2^ADDR_W cycles of mem_en, plus 1 cycle for clear_done.
- Worst-case wait for requester i with all requesters saturated: (N_REQ-1)*(RD_LAT+2) cycles after its turn begins.

## Structure
- Shared package sram_arb_pkg: state encoding (2-bit enum IDLE/ISSUE/WAIT/CLEAR) and the default ADDR_W/DATA_W constants used across the design.
- One sub-module, rr_pick: combinational rotate-priority picker. Inputs are an N_REQ-bit eligible mask and the last-grant index; outputs are a one-hot grant and a valid bit. It is reused by future bus arbiters.
- The SRAM macro stays outside this block.

## Test plan
- Reset release with CLEAR_ON_RESET=1 and ADDR_W=4: mem_we high for 16 consecutive cycles at addresses 0..15 with mem_wdata=0. Then one clear_done pulse, busy falls, and a read of address 7 returns 0.
- Single requester 0 writes 0xDEADBEEF to 0x0012, then reads 0x0012: each ack arrives 4 cycles after req (RD_LAT=2), and the read ack carries rdata=0xDEADBEEF.
- All four req held continuously: acks rotate 0,1,2,3,0,1 with exactly one ack per 4 cycles and no requester granted twice in a row.
- Requester 2 alone, holding req for one cycle after its ack: it is not re-granted in that IDLE cycle, and is granted on the next IDLE.
- clear_req pulsed during requester 1's WAIT: requester 1 is acked normally, CLEAR starts in the following IDLE, requester 3's pending req is acked only after clear_done, and its read of a previously written address returns 0.
- reset driven low during WAIT: no ack, all outputs reach their reset values on the next edge, and the clear sequence restarts from address 0.

Source files
------------

// File: rtl/sram_rr_arbiter_pkg.sv
// Shared definitions for the SRAM round-robin arbiter: sequencer state encoding
// and the default SRAM geometry used across the design.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CLEAR = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first eligible index strictly after
// the last grant, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] sel;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sel = IDX_W'((int'(last) + k) % N_REQ);
      if (!valid && eligible[sel]) begin
        grant[sel] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Shares one single-port SRAM between N_REQ requesters: round-robin grant,
// one access at a time with a fixed read latency, plus a full zero-fill.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RD_LAT         = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     clear_req,
  output logic                     clear_done,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WCNT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  winner;
  logic              winner_we;
  logic              clear_pend;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  pick_grant;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;

  // The requester being acked this cycle must not be re-granted in the same IDLE.
  assign eligible = req & ~ack;
  assign busy     = (state != S_IDLE);

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .eligible(eligible),
    .last    (last_grant),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) pick_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt    <= '0;
      wait_cnt   <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      winner     <= '0;
      winner_we  <= 1'b0;
      clear_pend <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      clear_done <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      ack        <= '0;
      clear_done <= 1'b0;
      // A clear arriving mid-transaction waits; one arriving mid-clear is dropped.
      if (clear_req && (state == S_ISSUE || state == S_WAIT)) clear_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (clear_pend || clear_req) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= S_CLEAR;
          end else if (pick_valid) begin
            winner    <= pick_idx;
            winner_we <= we[pick_idx];
            mem_en    <= 1'b1;
            mem_we    <= we[pick_idx];
            mem_addr  <= addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[pick_idx*DATA_W +: DATA_W];
            state     <= S_ISSUE;
          end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
        end

        S_ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= WCNT_W'(RD_LAT - 1);
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            if (!winner_we) rdata <= mem_rdata;
            ack[winner] <= 1'b1;
            last_grant  <= winner;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_CLEAR: begin
          // The final address is on the bus this cycle; close out next edge.
          if (mem_en && mem_addr == {ADDR_W{1'b1}}) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            clear_done <= 1'b1;
            clear_pend <= 1'b0;
            clr_cnt    <= '0;
            state      <= S_IDLE;
          end else begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= clr_cnt;
            mem_wdata <= '0;
            clr_cnt   <= clr_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: SRAM model with read latency, and a reference
// model of grant order, latency, memory contents and clear behaviour.
module tb_sram_rr_arbiter;

  localparam int N     = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int IW    = $clog2(N);
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = N*(RL+2) + DEPTH + 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic            clear_req = 1'b0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            clear_done, busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  sram_rr_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .clear_req(clear_req), .clear_done(clear_done),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // SRAM macro: read data appears RL cycles after the enable is sampled; junk otherwise.
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clock) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : DW'($urandom);
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rdata = '0;
  logic [N-1:0]  act = '0;
  logic          cw [N];
  logic [AW-1:0] ca [N];
  logic [DW-1:0] cd [N];
  int            since [N];
  int            ack_at [N];
  logic [N-1:0]  hist [64];
  int cyc = 0, last_g = N-1, last_ack_cyc = 0, n_cd = 0, cd_at = -1, clr_wr = 0;

  function automatic logic [IW-1:0] ix(input int i);
    return IW'(i);
  endfunction

  function automatic int rr_first(input logic [N-1:0] set, input int last);
    for (int k = 1; k <= N; k++)
      if (set[ix((last + k) % N)]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[ix(i)] = 1'b1;
    we[ix(i)]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
    act[ix(i)] = 1'b1;
    cw[ix(i)] = w; ca[ix(i)] = a; cd[ix(i)] = d; since[ix(i)] = cyc;
    hist[6'(cyc)] = req & ~ack;
  endtask

  task automatic model_sync();
    for (int i = 0; i < 64; i++) hist[i] = '0;
    last_ack_cyc = cyc;
  endtask

  // One clock of observation and checking, then optional new requests.
  task automatic step(input logic [N-1:0] en, input int pct);
    int idx, dcy, expg;
    bit gap_ok;
    @(negedge clock);
    cyc++;
    check("ack_onehot", ($countones(ack) <= 1), 1);
    if (clear_done) begin
      n_cd++;
      cd_at = cyc;
      last_ack_cyc = cyc;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end
    if (mem_en && mem_we && mem_wdata == '0 && mem_addr == AW'(clr_wr)) clr_wr++;
    if (ack != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (ack[ix(i)]) idx = i;
      dcy = cyc - (RL + 2);
      check("ack_pending", act[ix(idx)], 1);
      check("ack_spacing", (dcy >= last_ack_cyc), 1);
      expg = rr_first(hist[6'(dcy)], last_g);
      check("grant_order", idx, expg);
      gap_ok = 1'b1;
      for (int c = (last_ack_cyc > dcy - 63 ? last_ack_cyc : dcy - 63); c < dcy; c++)
        if (hist[6'(c)] != '0) gap_ok = 1'b0;
      check("no_idle_gap", gap_ok, 1);
      if (cw[ix(idx)]) ref_mem[ca[ix(idx)]] = cd[ix(idx)];
      else exp_rdata = ref_mem[ca[ix(idx)]];
      act[ix(idx)] = 1'b0;
      req[ix(idx)] = 1'b0;
      ack_at[ix(idx)] = cyc;
      last_g = idx;
      last_ack_cyc = cyc;
    end
    check("rdata", rdata, exp_rdata);
    for (int i = 0; i < N; i++) begin
      if (act[ix(i)] && (cyc - since[ix(i)]) > TMO) begin
        check("ack_timeout", cyc - since[ix(i)], TMO);
        act[ix(i)] = 1'b0;
        req[ix(i)] = 1'b0;
      end
    end
    if (pct > 0)
      for (int i = 0; i < N; i++)
        if (en[ix(i)] && !act[ix(i)] && $urandom_range(99) < pct)
          present(i, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
    hist[6'(cyc)] = req & ~ack;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (act != '0 && k < bound) begin
      step('0, 0);
      k++;
    end
    check("drain_idle", act, 0);
  endtask

  task automatic do_single(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t0, k;
    step('0, 0);
    present(i, w, a, d);
    t0 = cyc;
    k = 0;
    while (act[ix(i)] && k < TMO) begin
      step('0, 0);
      k++;
    end
    check("single_latency", cyc - t0, RL + 2);
  endtask

  // Called on the negedge where reset is released.
  task automatic expect_clear();
    int wr = 0, done_at = -1;
    bit seq_ok = 1'b1, quiet = 1'b1, busy_ok = 1'b1;
    for (int c = 1; c <= DEPTH + 10 && done_at < 0; c++) begin
      @(negedge clock);
      cyc++;
      if (mem_en) begin
        if (!mem_we || mem_wdata != '0 || mem_addr != AW'(wr)) seq_ok = 1'b0;
        wr++;
      end
      if (ack != '0) quiet = 1'b0;
      if (clear_done) done_at = c;
      else if (!busy) busy_ok = 1'b0;
    end
    check("clr_writes", wr, DEPTH);
    check("clr_order", seq_ok, 1);
    check("clr_no_ack", quiet, 1);
    check("clr_busy_high", busy_ok, 1);
    check("clr_done_cycle", done_at, DEPTH + 1);
    check("clr_busy_low", busy, 0);
    check("clr_mem_en_low", mem_en, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_sync();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    model_sync();

    // Reset values while held in reset
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 1);

    // Automatic zero-fill, then a read of address 7 returns zero
    reset = 1'b1;
    expect_clear();
    do_single(2, 1'b0, 5'd7, '0);
    check("read7_zero", rdata, 0);

    // Single requester write then read back
    do_single(0, 1'b1, 5'h12, 32'hDEADBEEF);
    do_single(0, 1'b0, 5'h12, '0);
    check("readback", rdata, 32'hDEADBEEF);

    // All requesters saturated
    repeat (40) step(4'hF, 100);
    drain(TMO);

    // Requester 2 alone, re-requesting immediately after each ack
    repeat (24) step(4'b0100, 100);
    drain(TMO);

    // Random mixed traffic
    repeat (300) step(4'hF, 35);
    drain(TMO);

    // clear_req during requester 1's WAIT; requester 3 waits behind the clear
    do_single(1, 1'b1, 5'd5, 32'h5A5A1234);
    step('0, 0);
    present(1, 1'b0, 5'd9, '0);
    t0 = cyc;
    clr_wr = 0;
    n_cd = 0;
    step('0, 0);
    step('0, 0);
    clear_req = 1'b1;
    present(3, 1'b0, 5'd5, '0);
    step('0, 0);
    clear_req = 1'b0;
    drain(TMO + 10);
    check("clr_req1_latency", ack_at[1] - t0, RL + 2);
    check("clr_done_count", n_cd, 1);
    check("clr_wr_count", clr_wr, DEPTH);
    check("clr_req3_after_done", ack_at[3] - cd_at, RL + 2);
    check("clr_read_zero", rdata, 0);

    // Reset during WAIT drops the transaction and restarts the clear
    do_single(1, 1'b1, 5'd9, 32'hCAFE0001);
    do_single(1, 1'b0, 5'd9, '0);
    check("pre_rst_read", rdata, 32'hCAFE0001);
    step('0, 0);
    present(0, 1'b0, 5'd9, '0);
    step('0, 0);
    step('0, 0);
    reset = 1'b0;
    req = '0;
    act = '0;
    @(negedge clock);
    cyc++;
    check("wrst_ack", ack, 0);
    check("wrst_rdata", rdata, 0);
    check("wrst_mem_en", mem_en, 0);
    check("wrst_mem_we", mem_we, 0);
    check("wrst_mem_addr", mem_addr, 0);
    check("wrst_mem_wdata", mem_wdata, 0);
    check("wrst_clear_done", clear_done, 0);
    check("wrst_busy", busy, 1);
    @(negedge clock);
    cyc++;
    check("wrst_no_late_ack", ack, 0);
    reset = 1'b1;
    last_g = N - 1;
    exp_rdata = '0;
    expect_clear();
    do_single(1, 1'b0, 5'd9, '0);
    check("post_rst_read_zero", rdata, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
